// File: rtl/thcattus_uart_tx_arbiter.sv
// Round-robin AXI-Stream arbiter that shares one UART TX between several requesters.
// Grants are held per burst: released on tlast, a beat limit, or source idle timeout.
module thcattus_uart_tx_arbiter #(
   parameter  int NUM_PORTS    = 4,
   parameter  int DATA_WIDTH   = 4,
   parameter  int MAX_BURST    = 16,
   parameter  int IDLE_TIMEOUT = 64,
   localparam int IDW          = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
   localparam int DW           = DATA_WIDTH * 8
) (
   input  logic                    axis_aclk,
   input  logic                    axis_arestn,
   input  logic [NUM_PORTS-1:0]    s_axis_tvalid,
   output logic [NUM_PORTS-1:0]    s_axis_tready,
   input  logic [NUM_PORTS*DW-1:0] s_axis_tdata,
   input  logic [NUM_PORTS-1:0]    s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DW-1:0]           m_axis_tdata,
   output logic                    m_axis_tlast,
   output logic [IDW-1:0]          m_axis_tid,
   output logic                    grant_active
);

   localparam int BCW = $clog2(MAX_BURST) + 1;
   localparam int ICW = $clog2(IDLE_TIMEOUT) + 1;
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(MAX_BURST - 1);
   localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_TIMEOUT - 1);
   localparam logic [IDW-1:0] RR_INIT   = IDW'(NUM_PORTS - 1);

   typedef enum logic {ST_IDLE, ST_XFER} state_t;

   state_t         r_state, w_state_next;
   logic [IDW-1:0] r_grant_id, w_grant_id_next;
   logic [IDW-1:0] r_rr_ptr, w_rr_ptr_next;
   logic [BCW-1:0] r_beat_cnt, w_beat_cnt_next;
   logic [ICW-1:0] r_idle_cnt, w_idle_cnt_next;

   logic           w_xfer, w_gnt_valid, w_gnt_last, w_hs, w_pick_found;
   logic [IDW-1:0] w_pick_id, w_idx;
   logic [DW-1:0]  w_gnt_data;

   assign w_xfer      = (r_state == ST_XFER);
   assign w_gnt_valid = s_axis_tvalid[r_grant_id];
   assign w_gnt_last  = s_axis_tlast[r_grant_id];
   assign w_gnt_data  = s_axis_tdata[r_grant_id*DW +: DW];
   assign w_hs        = w_xfer & w_gnt_valid & m_axis_tready;

   assign m_axis_tvalid = w_xfer & w_gnt_valid;
   assign m_axis_tdata  = w_gnt_data;
   assign m_axis_tlast  = w_gnt_last;
   assign m_axis_tid    = r_grant_id;
   assign grant_active  = w_xfer;

   always_comb begin
      s_axis_tready = '0;
      if (w_xfer) s_axis_tready[r_grant_id] = m_axis_tready;
   end

   // Scan from farthest to nearest so the port just after rr_ptr wins.
   always_comb begin
      w_pick_found = 1'b0;
      w_pick_id    = '0;
      w_idx        = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         w_idx = IDW'((int'(r_rr_ptr) + k) % NUM_PORTS);
         if (s_axis_tvalid[w_idx]) begin
            w_pick_found = 1'b1;
            w_pick_id    = w_idx;
         end
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_grant_id_next = r_grant_id;
      w_rr_ptr_next   = r_rr_ptr;
      w_beat_cnt_next = r_beat_cnt;
      w_idle_cnt_next = r_idle_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_found) begin
               w_grant_id_next = w_pick_id;
               w_beat_cnt_next = '0;
               w_idle_cnt_next = '0;
               w_state_next    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (w_hs) begin
               w_beat_cnt_next = r_beat_cnt + 1'b1;
               w_idle_cnt_next = '0;
               if (w_gnt_last || (r_beat_cnt == BEAT_LAST)) begin
                  w_rr_ptr_next = r_grant_id;
                  w_state_next  = ST_IDLE;
               end
            end else if (!w_gnt_valid) begin
               // Only source starvation ages the grant; sink backpressure does not.
               w_idle_cnt_next = r_idle_cnt + 1'b1;
               if (r_idle_cnt == IDLE_LAST) begin
                  w_rr_ptr_next = r_grant_id;
                  w_state_next  = ST_IDLE;
               end
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_arestn) begin
      if (!axis_arestn) begin
         r_state    <= ST_IDLE;
         r_grant_id <= '0;
         r_rr_ptr   <= RR_INIT;
         r_beat_cnt <= '0;
         r_idle_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_grant_id <= w_grant_id_next;
         r_rr_ptr   <= w_rr_ptr_next;
         r_beat_cnt <= w_beat_cnt_next;
         r_idle_cnt <= w_idle_cnt_next;
      end
   end

endmodule

// File: tb/tb_thcattus_uart_tx_arbiter.sv
// Directed bench for thcattus_uart_tx_arbiter: request latency, round robin,
// burst limit, idle timeout, backpressure and asynchronous reset.
module tb_thcattus_uart_tx_arbiter;

   localparam int NP = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          arestn;
   logic [NP-1:0] s_tvalid, s_tready, s_tlast;
   logic [NP*DW-1:0] s_tdata;
   logic          m_tvalid, m_tready, m_tlast, ga;
   logic [DW-1:0] m_tdata;
   logic [1:0]    m_tid;

   int n_total = 0;
   int n_fail  = 0;
   int order[5] = '{0, 1, 2, 3, 0};

   always #5 clk = ~clk;

   thcattus_uart_tx_arbiter #(
      .NUM_PORTS(4), .DATA_WIDTH(4), .MAX_BURST(16), .IDLE_TIMEOUT(64)
   ) dut (
      .axis_aclk     (clk),
      .axis_arestn   (arestn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .m_axis_tid    (m_tid),
      .grant_active  (ga)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_data(input int p, input logic [DW-1:0] v);
      s_tdata[p*DW +: DW] = v;
   endtask

   task automatic do_reset();
      arestn = 1'b0;
      #1;
      @(posedge clk);
      #2;
      arestn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arestn = 1'b0; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
      #1;
      chk("reset_outputs", {ga, m_tvalid, s_tready, m_tid}, 64'h0);
      @(posedge clk); #2;
      arestn = 1'b1;

      // Single requester on port 2, three beats
      s_tvalid = 4'b0100; set_data(2, 32'h11); m_tready = 1'b1; #1;
      chk("single_idle", {ga, m_tvalid, s_tready}, 64'h0);
      step(); #1;
      chk("single_grant", {ga, m_tvalid, m_tid, s_tready}, {1'b1, 1'b1, 2'd2, 4'b0100});
      chk("single_b1", m_tdata, 32'h11);
      $display("single: beat 0x11 tid=%0d", m_tid);
      step(); set_data(2, 32'h22); #1;
      chk("single_b2", {ga, m_tdata}, {1'b1, 32'h22});
      $display("single: beat 0x22 tid=%0d", m_tid);
      step(); set_data(2, 32'h33); s_tlast = 4'b0100; #1;
      chk("single_b3", {ga, m_tlast, m_tdata}, {1'b1, 1'b1, 32'h33});
      $display("single: beat 0x33 tid=%0d", m_tid);
      step(); s_tvalid = '0; s_tlast = '0; #1;
      chk("single_release", {ga, m_tvalid, s_tready}, 64'h0);

      // All ports requesting with 1-beat messages
      do_reset();
      s_tvalid = 4'hF; s_tlast = 4'hF; m_tready = 1'b1;
      for (int p = 0; p < NP; p++) set_data(p, 32'hA0 + p);
      #1;
      chk("rr_idle", m_tvalid, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(); #1;
         chk("rr_grant", {m_tvalid, m_tid, m_tdata}, {1'b1, 2'(order[i]), 32'hA0 + 32'(order[i])});
         $display("rr: grant tid=%0d data=%0h", m_tid, m_tdata);
         step(); #1;
         chk("rr_bubble", {ga, m_tvalid}, 64'h0);
      end
      s_tvalid = '0; s_tlast = '0;

      // Burst limit: port 1 streams 20 beats, port 3 waits
      do_reset();
      s_tvalid = 4'b1010; s_tlast = 4'b1000; set_data(1, 32'd1); set_data(3, 32'h33); #1;
      step();
      for (int b = 1; b <= 16; b++) begin
         set_data(1, 32'(b)); #1;
         chk("burst_beat", {m_tid, m_tdata}, {2'd1, 32'(b)});
         $display("burst: tid=%0d beat=%0d", m_tid, m_tdata);
         step();
      end
      set_data(1, 32'd17); #1;
      chk("burst_limit_release", ga, 1'b0);
      step(); #1;
      chk("burst_next_port", {ga, m_tid, m_tdata}, {1'b1, 2'd3, 32'h33});
      step(); s_tvalid[3] = 1'b0; #1;
      chk("burst_p3_release", ga, 1'b0);
      step();
      for (int b = 17; b <= 20; b++) begin
         set_data(1, 32'(b));
         if (b == 20) s_tlast[1] = 1'b1;
         #1;
         chk("burst_resume", {m_tid, m_tdata}, {2'd1, 32'(b)});
         $display("burst: tid=%0d beat=%0d", m_tid, m_tdata);
         step();
      end
      s_tvalid = '0; s_tlast = '0; #1;
      chk("burst_end", ga, 1'b0);

      // Idle timeout: port 0 starves after one beat while port 1 waits
      do_reset();
      s_tvalid = 4'b0011; s_tlast = '0; set_data(0, 32'h55); set_data(1, 32'h66); #1;
      step(); #1;
      chk("to_grant0", {m_tid, m_tdata}, {2'd0, 32'h55});
      step(); s_tvalid[0] = 1'b0; #1;
      for (int i = 1; i <= 64; i++) begin
         chk("to_hold", {ga, m_tid, m_tvalid, s_tready}, {1'b1, 2'd0, 1'b0, 4'b0001});
         step(); #1;
      end
      chk("to_release", ga, 1'b0);
      $display("timeout: grant released after 64 idle cycles");
      step(); #1;
      chk("to_grant1", {ga, m_tid, m_tdata}, {1'b1, 2'd1, 32'h66});
      s_tlast[1] = 1'b1;
      step(); s_tvalid = '0; s_tlast = '0; #1;
      chk("to_p1_release", ga, 1'b0);

      // Backpressure: sink stalls 200 cycles
      s_tvalid = 4'b0100; s_tlast = 4'b0100; set_data(2, 32'h77); m_tready = 1'b0; #1;
      step(); #1;
      chk("bp_grant", {m_tid, m_tvalid}, {2'd2, 1'b1});
      for (int i = 0; i < 200; i++) begin
         chk("bp_hold", {ga, m_tvalid, s_tready, m_tdata}, {1'b1, 1'b1, 4'b0000, 32'h77});
         step(); #1;
      end
      m_tready = 1'b1; #1;
      chk("bp_ready", s_tready, 4'b0100);
      step(); s_tvalid = '0; s_tlast = '0; #1;
      chk("bp_release", ga, 1'b0);
      $display("backpressure: beat 0x77 delivered after 200 stall cycles");

      // Reset mid-burst
      s_tvalid = 4'b1001; s_tlast = '0; set_data(0, 32'hA5); set_data(3, 32'h5A); #1;
      step(); #1;
      chk("rst_pre_grant", {m_tid, m_tdata}, {2'd3, 32'h5A});
      step();
      arestn = 1'b0; #1;
      chk("rst_async", {ga, m_tvalid, s_tready, m_tid}, 64'h0);
      step(); arestn = 1'b1; #1;
      chk("rst_idle", {ga, m_tvalid}, 64'h0);
      step(); #1;
      chk("rst_first_grant", {ga, m_tid, m_tdata}, {1'b1, 2'd0, 32'hA5});
      $display("reset: first grant tid=%0d", m_tid);
      s_tvalid = '0;

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule

// File: doc/thcattus_uart_tx_arbiter.md
# thcattus_uart_tx_arbiter

Round-robin AXI-Stream arbiter that shares one UART transmitter between several requesters. It accepts up to NUM_PORTS slave streams and forwards one granted stream at a time to a single master port feeding the UART TX. Grants are burst-granular: a grant holds until tlast, a beat limit, or an idle timeout, so a requester's bytes are not interleaved with another's mid-message. The block sits between the CPU/debug stream sources and the UART TX serializer.

## Interface

Parameters:
- NUM_PORTS, 4: number of slave requesters, 2..16.
- DATA_WIDTH, 4: bus width in bytes, the same on all ports.
- MAX_BURST, 16: maximum beats per grant, at least 1.
- IDLE_TIMEOUT, 64: consecutive cycles with the granted tvalid low before the grant is revoked, at least 1.

Ports:
- axis_aclk, in, 1: single clock.
- axis_arestn, in, 1: reset, asynchronous, active-low.
- s_axis_tvalid, in, NUM_PORTS: per-requester valid; bit i belongs to port i.
- s_axis_tready, out, NUM_PORTS: per-requester ready.
- s_axis_tdata, in, NUM_PORTS*DATA_WIDTH*8: port i occupies slice [i*DATA_WIDTH*8 +: DATA_WIDTH*8].
- s_axis_tlast, in, NUM_PORTS: per-requester end of message.
- m_axis_tvalid, out, 1: valid toward the UART TX.
- m_axis_tready, in, 1: ready from the UART TX.
- m_axis_tdata, out, DATA_WIDTH*8: data from the granted port.
- m_axis_tlast, out, 1: tlast from the granted port.
- m_axis_tid, out, IDW: granted port index; IDW = max(1, clog2(NUM_PORTS)).
- grant_active, out, 1: high while in XFER.

## Operation

- Two states, IDLE and XFER. Registered state: the state itself, grant_id (IDW bits), rr_ptr (IDW bits), beat_cnt (clog2(MAX_BURST)+1 bits) and idle_cnt (clog2(IDLE_TIMEOUT)+1 bits).
- Reset values:
  - state = IDLE, grant_id = 0, rr_ptr = NUM_PORTS-1, beat_cnt = 0, idle_cnt = 0.
  - Outputs: m_axis_tvalid = 0, s_axis_tready = 0, grant_active = 0, m_axis_tid = 0. m_axis_tdata and m_axis_tlast reflect port 0 and are don't-care.
- IDLE:
  - All s_axis_tready = 0 and m_axis_tvalid = 0.
  - If any s_axis_tvalid bit is set, select the first set bit searching upward from rr_ptr+1, wrapping modulo NUM_PORTS. Load grant_id with it, clear beat_cnt and idle_cnt, and go to XFER.
- XFER datapath:
  - The datapath is combinational, with no buffering:
    - m_axis_tvalid = s_axis_tvalid[grant_id]
    - m_axis_tdata and m_axis_tlast come from port grant_id.
    - s_axis_tready[grant_id] = m_axis_tready; all other ready bits are 0.
  - m_axis_tid = grant_id.
- XFER handshake (m_axis_tvalid & m_axis_tready): beat_cnt increments and idle_cnt clears.
  - If tlast is set or beat_cnt == MAX_BURST-1: set rr_ptr = grant_id and go to IDLE.
- XFER with the granted tvalid low: idle_cnt increments.
  - When idle_cnt == IDLE_TIMEOUT-1: set rr_ptr = grant_id and go to IDLE.
- Valid high without ready: no counter changes. The timeout only measures source starvation, never sink backpressure.
- Fairness: a port just released has the lowest priority at the next arbitration. With all ports requesting, the grant order is 0,1,…,N-1,0,…
- Reset asserted mid-XFER: immediate return to reset values. Any in-flight beat is dropped and the sources must resend.

## Timing

- Request latency:
  - A tvalid rising in IDLE at edge N is granted at edge N+1; m_axis_tvalid is high during cycle N+1.
  - A single isolated request therefore costs 1 cycle of arbitration.
- Release:
  - The terminating handshake at edge M puts the block in IDLE during cycle M+1, with all ready bits low.
  - The next grant takes effect at M+2. There is exactly one bubble cycle between grants.
- Throughput: one beat per cycle while granted and the sink is ready.
- The output is combinational from the inputs during XFER; the downstream UART TX must register its inputs.
- A requester that deasserts valid while still granted loses no data. It keeps the grant until IDLE_TIMEOUT expires.

## Test plan

- Single requester: port 2 sends 3 beats (0x11, 0x22, 0x33 with tlast) and the sink is always ready. Expect m_axis_tid = 2, output beats on 3 consecutive cycles starting 1 cycle after tvalid, and grant_active falling the cycle after the 0x33 handshake.
- All 4 ports request continuously with 1-beat tlast messages. Expect the grant order 0,1,2,3,0, with exactly one idle cycle between beats.
- Burst limit with MAX_BURST=16: port 1 streams 20 beats with no tlast. Expect release after beat 16; a waiting port 3 is granted next, and port 1 resumes later with beat 17 intact.
- Idle timeout with IDLE_TIMEOUT=64: port 0 sends 1 non-last beat, then drops tvalid while port 1 requests. Expect port 0's grant to end after 64 low cycles, then port 1 is granted.
- Backpressure: m_axis_tready is held low for 200 cycles during a grant. Expect no timeout, tdata stable, and s_axis_tready low on all ports.
- Reset mid-burst: pull axis_arestn low during XFER. Expect all outputs at reset values asynchronously, and port 0 winning first after release.
